// File: rtl/branch_predictor_bht.sv
// Per-PC branch predictor: a table of saturating-counter entries (BHT) with
// tagged targets (BTB). Lookup is combinational, training is registered, and
// an init walk clears the table after reset so it can live in block RAM.
module branch_predictor_bht #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned IDX_BITS  = $clog2(ENTRIES),
  parameter int unsigned TAG_BITS  = 8,
  parameter int unsigned CNT_BITS  = 2,
  parameter int unsigned STAT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lookup_en,
  input  logic [XLEN-1:0]      pc_f,
  output logic                 pred_taken,
  output logic [XLEN-1:0]      pred_npc,
  output logic                 ready,
  input  logic                 upd_valid,
  input  logic [XLEN-1:0]      upd_pc,
  input  logic                 upd_taken,
  input  logic                 upd_uncond,
  input  logic [XLEN-1:0]      upd_target,
  input  logic                 upd_mispredict,
  output logic [STAT_BITS-1:0] stat_lookups,
  output logic [STAT_BITS-1:0] stat_mispredicts
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);
  localparam logic [IDX_BITS-1:0] PTR_LAST = IDX_BITS'(ENTRIES - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_BITS-1:0]   ptr_q, ptr_d;
  logic                  ready_q, ready_d;
  logic [STAT_BITS-1:0]  stat_lookups_q, stat_lookups_d;
  logic [STAT_BITS-1:0]  stat_mispredicts_q, stat_mispredicts_d;

  // Table storage; no reset, the init walk clears it.
  logic                  valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]       target_q [ENTRIES];
  logic [CNT_BITS-1:0]   cnt_q    [ENTRIES];

  // Single write port shared by the init walk and training.
  logic                  wr_en;
  logic [IDX_BITS-1:0]   wr_idx;
  logic                  valid_d;
  logic [TAG_BITS-1:0]   tag_d;
  logic [XLEN-1:0]       target_d;
  logic [CNT_BITS-1:0]   cnt_d;

  logic [IDX_BITS-1:0]   lk_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic                  lk_hit;
  logic [IDX_BITS-1:0]   up_idx;
  logic [TAG_BITS-1:0]   up_tag;
  logic                  up_hit;

  // Only the index/tag fields of the PCs are used.
  logic                  unused_pc_bits;
  assign unused_pc_bits = ^{pc_f, upd_pc};

  assign lk_idx = pc_f[IDX_BITS+1:2];
  assign lk_tag = pc_f[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign up_idx = upd_pc[IDX_BITS+1:2];
  assign up_tag = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Fetch-side prediction from current table contents (no update bypass).
  always_comb begin
    lk_hit     = ready_q && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken = lk_hit && (cnt_q[lk_idx] >= CNT_WT);
    pred_npc   = pred_taken ? target_q[lk_idx] : pc_f + XLEN'(4);
  end

  // Init/run sequencing and saturating statistics.
  always_comb begin
    state_d            = state_q;
    ptr_d              = ptr_q;
    ready_d            = ready_q;
    stat_lookups_d     = stat_lookups_q;
    stat_mispredicts_d = stat_mispredicts_q;
    case (state_q)
      S_INIT: begin
        ptr_d = ptr_q + IDX_BITS'(1);
        if (ptr_q == PTR_LAST) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (lookup_en && ready_q && (stat_lookups_q != '1))
      stat_lookups_d = stat_lookups_q + STAT_BITS'(1);
    if (upd_valid && upd_mispredict && ready_q && (stat_mispredicts_q != '1))
      stat_mispredicts_d = stat_mispredicts_q + STAT_BITS'(1);
  end

  // Control state register; reset restarts the walk from index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= S_INIT;
      ptr_q              <= '0;
      ready_q            <= 1'b0;
      stat_lookups_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      state_q            <= state_d;
      ptr_q              <= ptr_d;
      ready_q            <= ready_d;
      stat_lookups_q     <= stat_lookups_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  // Write-port arbitration: init walk clears, otherwise train from execute.
  always_comb begin
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    wr_en    = 1'b0;
    wr_idx   = up_idx;
    valid_d  = 1'b1;
    tag_d    = up_tag;
    target_d = target_q[up_idx];
    cnt_d    = cnt_q[up_idx];
    if (state_q == S_INIT) begin
      wr_en    = 1'b1;
      wr_idx   = ptr_q;
      valid_d  = 1'b0;
      tag_d    = '0;
      target_d = '0;
      cnt_d    = CNT_WNT;
    end else if (upd_valid) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (upd_uncond) begin
          cnt_d    = CNT_MAX;
          target_d = upd_target;
        end else if (upd_taken) begin
          if (cnt_q[up_idx] != CNT_MAX)
            cnt_d = cnt_q[up_idx] + CNT_BITS'(1);
          target_d = upd_target;
        end else if (cnt_q[up_idx] != '0) begin
          cnt_d = cnt_q[up_idx] - CNT_BITS'(1);
        end
      end else if (upd_taken || upd_uncond) begin
        wr_en    = 1'b1;
        target_d = upd_target;
        cnt_d    = upd_uncond ? CNT_MAX : CNT_WT;
      end
    end
    if (reset)
      wr_en = 1'b0;
  end

  // Table write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      valid_q[wr_idx]  <= valid_d;
      tag_q[wr_idx]    <= tag_d;
      target_q[wr_idx] <= target_d;
      cnt_q[wr_idx]    <= cnt_d;
    end
  end

  assign ready            = ready_q;
  assign stat_lookups     = stat_lookups_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised per-PC branch predictor for the fetch stage: branch history table (BHT) of saturating counters plus tagged branch target buffer (BTB).
- Replaces the single global 4-state predictor.
- Fetch presents its PC combinationally and receives a predicted next PC the same cycle.
- Execute reports resolved branches, which train the tables the following clock edge.
- An init state machine walks the tables after reset, so the arrays can map onto block RAM.

Parameters:
- XLEN, 32, address/PC width.
- ENTRIES, 64, table entries; power of two, ≥2.
- IDX_BITS, log2(ENTRIES), index width.
- TAG_BITS, 8, stored tag width; 1 ≤ TAG_BITS ≤ XLEN-IDX_BITS-2.
- CNT_BITS, 2, saturating counter width; ≥1.
- STAT_BITS, 32, width of statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- lookup_en  in  1  fetch lookup valid this cycle (low during stallF)
- pc_f  in  XLEN  fetch PC
- pred_taken  out  1  prediction: taken
- pred_npc  out  XLEN  predicted next PC
- ready  out  1  init walk complete; tables valid
- upd_valid  in  1  resolved control transfer from execute
- upd_pc  in  XLEN  PC of resolved instruction
- upd_taken  in  1  actual outcome
- upd_uncond  in  1  JAL/JALR (unconditional)
- upd_target  in  XLEN  actual target
- upd_mispredict  in  1  execute detected misprediction (failure)
- stat_lookups  out  STAT_BITS  count of accepted lookups
- stat_mispredicts  out  STAT_BITS  count of reported mispredictions

Behaviour:
- Address fields:
  - index = pc[IDX_BITS+1:2]
  - tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]
  - PC bits [1:0] ignored.
- Per entry: valid (1), tag, target (XLEN), counter (CNT_BITS).
  - WNT = 2^(CNT_BITS-1)-1, WT = 2^(CNT_BITS-1), MAX = 2^CNT_BITS-1.
  - Predict taken iff counter ≥ WT.
- FSM states INIT and RUN.
  - reset=1 at an edge: next state INIT, walk pointer ←0, stat counters ←0, ready ←0; this applies even mid-walk or mid-run.
  - INIT: each cycle write entry[ptr] = {valid 0, counter WNT}; ptr++.
  - After writing ENTRIES-1, go to RUN and set ready=1. ready rises exactly ENTRIES cycles after reset deasserts.
- Lookup is combinational.
  - hit = ready & valid & tag match.
  - pred_taken = hit & counter ≥ WT.
  - pred_npc = pred_taken ? target : pc_f+4, with wrap modulo 2^XLEN.
  - While ready=0: pred_taken=0, pred_npc=pc_f+4.
- Update is registered and takes effect at the edge after upd_valid. Ignored while ready=0 (INIT owns the write port).
  - Hit, conditional: counter +1 if taken, −1 if not; saturate at MAX/0; target ← upd_target if taken.
  - Hit, upd_uncond: counter ← MAX, target ← upd_target.
  - Miss, taken or uncond: allocate; valid←1, tag, target; counter ← MAX if uncond else WT. Overwrites any aliasing entry.
  - Miss, not-taken conditional: no change.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. No bypass.
- Reset output values:
  - ready=0, pred_taken=0, pred_npc=pc_f+4.
  - stat_lookups=0, stat_mispredicts=0.
- Statistics:
  - stat_lookups increments on lookup_en & ready.
  - stat_mispredicts increments on upd_valid & upd_mispredict & ready.
  - Both saturate at all-ones; no wrap.
- Outputs reflect table state only. The block never stalls fetch; redirect on misprediction is fetch/sequencer responsibility.

Test Plan (ENTRIES=16, CNT_BITS=2, TAG_BITS=8, XLEN=32):
1. Pulse reset 1 cycle, then lookup pc_f=0x8000 each cycle.
   - ready=0 for 16 cycles, then 1.
   - pred_npc=0x8004, pred_taken=0 throughout.
2. Train: upd pc=0x8010 taken target=0x8100 (cond, miss).
   - Next cycle lookup 0x8010 → pred_taken=1, pred_npc=0x8100 (counter=2).
   - Two not-taken updates → counter 1, then 0; pred_npc=0x8014.
   - Third not-taken → stays 0.
3. Saturation up: four taken updates on 0x8010 → counter stays 3. One not-taken → still predicts taken (counter 2).
4. Alias: entry at 0x8010 valid; lookup 0x8410 (same index, different tag) → miss, pred_npc=0x8414. Taken update at 0x8410 replaces the entry; 0x8010 now misses.
5. Simultaneous: lookup 0x8020 in the same cycle as the first taken update to 0x8020.
   - That cycle: pred_npc=0x8024.
   - Next cycle: pred_npc=target.
   - Uncond update on a not-taken-trained entry → counter 3 immediately.
6. Stats/reset mid-run: 5 lookups, 2 mispredicts → stat_lookups=5, stat_mispredicts=2. Reset during a later walk → both 0, ready=0, walk restarts at index 0, prior entries all miss afterwards.
